// File: rtl/timer_seq_ctrl.sv
// Programmable tick sequencer: runs a small instruction program (STOP/RUN/PAUSE/JUMP)
// against a clock prescaler, emitting tick pulses and a done pulse on STOP.
module timer_seq_ctrl #(
  parameter int unsigned DIV        = 50_000_000,
  parameter int unsigned PROG_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_wdata,
  output logic       tick,
  output logic [7:0] unit_tick,
  output logic       busy,
  output logic       done,
  output logic [3:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RUN,
    S_PAUSE
  } state_t;

  typedef enum logic [1:0] {
    OP_STOP,
    OP_RUN,
    OP_PAUSE,
    OP_JUMP
  } op_t;

  localparam int unsigned        PW       = $clog2(DIV);
  localparam logic [PW-1:0]      PRE_LAST = PW'(DIV - 1);

  logic [7:0]    mem [PROG_DEPTH];

  state_t        state, state_next;
  logic [7:0]    ir, ir_next;
  logic [PW-1:0] pre, pre_next;
  logic [5:0]    rem, rem_next;
  logic [3:0]    pc_next;
  logic [7:0]    unit_next;
  logic          tick_next, done_next, busy_next;

  op_t           op;
  logic [5:0]    operand;
  logic          period_end;

  assign op         = op_t'(ir[7:6]);
  assign operand    = ir[5:0];
  assign period_end = (pre == PRE_LAST);

  // Program memory is deliberately outside the reset domain so it survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_next = S_FETCH;
        S_FETCH:  state_next = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_STOP:  state_next = S_IDLE;
            OP_RUN:   state_next = (operand == '0) ? S_FETCH : S_RUN;
            OP_PAUSE: state_next = (operand == '0) ? S_FETCH : S_PAUSE;
            OP_JUMP:  state_next = S_FETCH;
            default:  state_next = S_IDLE;
          endcase
        end
        S_RUN, S_PAUSE: begin
          if (period_end && (rem == 6'd1)) state_next = S_FETCH;
        end
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    ir_next   = ir;
    pre_next  = pre;
    rem_next  = rem;
    pc_next   = pc;
    unit_next = unit_tick;
    tick_next = 1'b0;
    done_next = 1'b0;
    busy_next = (state_next != S_IDLE);
    if (abort) begin
      pre_next = '0;
      rem_next = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc_next   = '0;
            unit_next = '0;
          end
        end
        S_FETCH:  ir_next = mem[pc];
        S_DECODE: begin
          case (op)
            OP_STOP:  done_next = 1'b1;
            OP_RUN, OP_PAUSE: begin
              if (operand == '0) begin
                pc_next = pc + 4'd1;
              end else begin
                rem_next = operand;
                pre_next = '0;
              end
            end
            OP_JUMP:  pc_next = ir[3:0];
            default:  ;
          endcase
        end
        S_RUN, S_PAUSE: begin
          if (period_end) begin
            pre_next = '0;
            rem_next = rem - 6'd1;
            if (state == S_RUN) begin
              tick_next = 1'b1;
              unit_next = unit_tick + 8'd1;
            end
            if (rem == 6'd1) pc_next = pc + 4'd1;
          end else begin
            pre_next = pre + 1'b1;
          end
        end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir        <= '0;
      pre       <= '0;
      rem       <= '0;
      pc        <= '0;
      unit_tick <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ir        <= ir_next;
      pre       <= pre_next;
      rem       <= rem_next;
      pc        <= pc_next;
      unit_tick <= unit_next;
      tick      <= tick_next;
      done      <= done_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Scoreboard bench for timer_seq_ctrl at DIV=4: expected tick/done events are queued
// at launch and matched against the DUT's pulses as they appear.
module tb_timer_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_wdata = '0;
  logic       tick;
  logic [7:0] unit_tick;
  logic       busy;
  logic       done;
  logic [3:0] pc;

  timer_seq_ctrl #(.DIV(4), .PROG_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .tick       (tick),
    .unit_tick  (unit_tick),
    .busy       (busy),
    .done       (done),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int unsigned at;
    logic [7:0]  unit;
    logic [3:0]  pc;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned base = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  string       scen = "init";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %0d expected %0d (cycle %0d)", scen, tag, got, exp, cyc);
  endtask

  task automatic push_ev(input bit d, input int unsigned off, input int unsigned u,
                         input int unsigned p);
    ev_t ev;
    ev.is_done = d;
    ev.at      = base + off;
    ev.unit    = 8'(u);
    ev.pc      = 4'(p);
    exp_q.push_back(ev);
  endtask

  always @(negedge clk) begin
    if (rst && (tick || done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, tick, done}, 32'd0);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("kind_is_done", done, ev.is_done);
        check("cycle", cyc, ev.at);
        check("unit_tick", unit_tick, ev.unit);
        if (ev.is_done) begin
          check("busy_at_done", busy, 0);
          check("pc_at_done", pc, ev.pc);
        end
      end
    end
  end

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    base  = cyc + 1;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic push_run2_stop();
    push_ev(0, 6, 1, 0);
    push_ev(0, 10, 2, 0);
    push_ev(1, 12, 2, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    scen = "reset";
    repeat (2) @(negedge clk);
    check("tick", tick, 0);
    check("done", done, 0);
    check("busy", busy, 0);
    check("unit_tick", unit_tick, 0);
    check("pc", pc, 0);
    rst = 1'b1;

    scen = "abort_start_idle";
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("busy", busy, 0);

    scen = "run2_stop";
    write_word(4'd0, 8'h42);
    write_word(4'd1, 8'h00);
    launch();
    push_run2_stop();
    drain(100);

    scen = "pause3_run1_stop";
    write_word(4'd0, 8'h83);
    write_word(4'd1, 8'h41);
    write_word(4'd2, 8'h00);
    launch();
    push_ev(0, 20, 1, 0);
    push_ev(1, 22, 1, 2);
    drain(100);

    scen = "run1_jump_abort";
    write_word(4'd0, 8'h41);
    write_word(4'd1, 8'hC0);
    launch();
    for (int k = 0; k < 5; k++) push_ev(0, 6 + 8 * k, k + 1, 0);
    drain(200);
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    check("busy_after_abort", busy, 0);
    check("unit_tick_after_abort", unit_tick, 5);
    check("pc_after_abort", pc, 1);
    repeat (12) @(negedge clk);
    check("still_idle", busy, 0);

    scen = "run0_stop";
    write_word(4'd0, 8'h40);
    write_word(4'd1, 8'h00);
    launch();
    push_ev(1, 4, 0, 1);
    drain(50);

    scen = "jump_self";
    write_word(4'd0, 8'hC0);
    launch();
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("busy_looping", busy, 1);
    check("unit_tick_looping", unit_tick, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("busy_after_abort", busy, 0);

    scen = "write_while_busy";
    write_word(4'd0, 8'h42);
    write_word(4'd1, 8'h00);
    launch();
    push_run2_stop();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 8'h00; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    drain(100);
    scen = "relaunch_after_write";
    launch();
    push_run2_stop();
    drain(100);

    scen = "reset_mid_run";
    launch();
    push_ev(0, 6, 1, 0);
    drain(100);
    rst = 1'b0;
    #1;
    check("tick", tick, 0);
    check("done", done, 0);
    check("busy", busy, 0);
    check("unit_tick", unit_tick, 0);
    check("pc", pc, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("busy_after_release", busy, 0);
    scen = "program_intact";
    launch();
    push_run2_stop();
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
